// File: rtl/dcache_write_buffer_if.sv
// Bundle of the D_cache-side and slow_memD-side block transfer signals.
// slave = the write buffer, master = the cache/memory environment around it.
interface dcache_write_buffer_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);
  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic [DATA_W-1:0] cache_rdata;
  logic              cache_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
    output cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
    input  cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between D_cache and slow_memD: absorbs block write-backs,
// drains them in FIFO order and forwards buffered data to read requests.
module dcache_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_write_buffer_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_RRESP} state_t;

  state_t            state;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              cache_ready_q;
  logic [DATA_W-1:0] cache_rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              rd_hit;
  logic [PW-1:0]     rd_idx;
  logic              wr_match;
  logic [PW-1:0]     wr_idx;
  logic              req_ok;
  logic              rd_req;
  logic              wr_req;
  logic              wr_coal;
  logic              do_alloc;
  logic              do_pop;
  logic              rd_hit_acc;
  logic              rd_miss;
  logic              head_fwd;

  // Scan oldest to youngest so the last match found is the youngest one.
  // The head entry is excluded from coalescing while its drain is in flight.
  always_comb begin
    rd_hit   = 1'b0;
    rd_idx   = '0;
    wr_match = 1'b0;
    wr_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head + PW'(i);
      if (valid[idx] && addr_q[idx] == bus.cache_addr) begin
        rd_hit = 1'b1;
        rd_idx = idx;
        if (!(state == S_DRAIN && idx == head)) begin
          wr_match = 1'b1;
          wr_idx   = idx;
        end
      end
    end
  end

  // The cache holds one request at a time; nothing is taken during the read
  // miss itself or in the cycle the previous completion is signalled.
  assign req_ok     = !cache_ready_q && state != S_READ && state != S_RRESP;
  assign rd_req     = req_ok && bus.cache_read;
  assign wr_req     = req_ok && bus.cache_write && !bus.cache_read;
  assign wr_coal    = wr_req && wr_match;
  assign do_alloc   = wr_req && !wr_match && count != CW'(DEPTH);
  assign rd_hit_acc = rd_req && rd_hit;
  assign rd_miss    = rd_req && !rd_hit;
  assign do_pop     = state == S_DRAIN && bus.mem_ready;
  assign head_fwd   = wr_coal && wr_idx == head;

  // Entry payload storage, no reset needed: validity lives in valid.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      addr_q[tail] <= bus.cache_addr;
      data_q[tail] <= bus.cache_wdata;
    end
    if (wr_coal) begin
      data_q[wr_idx] <= bus.cache_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      valid         <= '0;
      cache_ready_q <= 1'b0;
      cache_rdata_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      cache_ready_q <= 1'b0;
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      count <= count + CW'(do_alloc) - CW'(do_pop);

      if (wr_coal || do_alloc || rd_hit_acc) begin
        cache_ready_q <= 1'b1;
      end
      if (rd_hit_acc) begin
        cache_rdata_q <= data_q[rd_idx];
      end

      unique case (state)
        S_IDLE: begin
          if (rd_miss) begin
            state      <= S_READ;
            mem_read_q <= 1'b1;
            mem_addr_q <= bus.cache_addr;
          end else if (count != '0) begin
            // A same-cycle coalesce into the head must reach memory.
            state       <= S_DRAIN;
            mem_write_q <= 1'b1;
            mem_addr_q  <= addr_q[head];
            mem_wdata_q <= head_fwd ? bus.cache_wdata : data_q[head];
          end
        end
        S_DRAIN: begin
          if (bus.mem_ready) begin
            mem_write_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_READ: begin
          if (bus.mem_ready) begin
            mem_read_q    <= 1'b0;
            cache_rdata_q <= bus.mem_rdata;
            cache_ready_q <= 1'b1;
            state         <= S_RRESP;
          end
        end
        S_RRESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cache_ready = cache_ready_q;
  assign bus.cache_rdata = cache_rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: table of cache transactions against a
// stalled memory plus hand sequences for drain ordering, read misses and reset.
module tb_dcache_write_buffer;

  logic clk;
  logic rst_n;

  dcache_write_buffer_if #(.ADDR_W(28), .DATA_W(128)) bus ();

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(28), .DATA_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    int           exp_lat;
    int           exp_count;
  } vec_t;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mlog_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           retire_cyc = 0;
  int           rd_cnt = 0;
  int           mem_cnt = 0;
  int           mem_lat = 8;
  bit           mem_stall = 1'b1;
  mlog_t        mlog [$];
  logic [127:0] mem_arr [logic [27:0]];

  function automatic logic [127:0] mem_pat(input logic [27:0] a);
    return {4{4'hC, a}};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_read === 1'b1) rd_cnt = rd_cnt + 1;
  end

  // Slow memory: answers a held request after mem_lat cycles with a one-cycle pulse.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      mem_cnt = 0;
    end else if (bus.mem_ready) begin
      bus.mem_ready = 1'b0;
    end else if ((bus.mem_read || bus.mem_write) && !mem_stall) begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt >= mem_lat) begin
        mem_cnt = 0;
        bus.mem_ready = 1'b1;
        retire_cyc = cyc + 1;
        if (bus.mem_write) begin
          mlog.push_back('{1'b1, bus.mem_addr, bus.mem_wdata});
          mem_arr[bus.mem_addr] = bus.mem_wdata;
        end else begin
          bus.mem_rdata = mem_pat(bus.mem_addr);
          mlog.push_back('{1'b0, bus.mem_addr, 128'h0});
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    bus.cache_addr  = '0;
    bus.cache_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One cache request; lat = cycles until cache_ready (-1 on timeout), then an idle cycle.
  task automatic xact(input bit wr, input logic [27:0] a, input logic [127:0] d,
                      input int maxc, output int lat, output logic [127:0] rd);
    lat = -1;
    rd  = '0;
    bus.cache_read  = !wr;
    bus.cache_write = wr;
    bus.cache_addr  = a;
    bus.cache_wdata = d;
    for (int n = 1; n <= maxc; n++) begin
      @(posedge clk);
      #1;
      if (bus.cache_ready) begin
        lat = n;
        rd  = bus.cache_rdata;
        break;
      end
    end
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit done;
    done = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(posedge clk);
      #1;
      if (dut.count == '0 && !bus.mem_write && !bus.mem_read) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 128'(done), 128'(1));
  endtask

  task automatic chk_log(input string name, input int idx, input bit wr,
                         input logic [27:0] a, input logic [127:0] d);
    if (idx < mlog.size()) begin
      chk({name, "_kind"}, 128'(mlog[idx].wr), 128'(wr));
      chk({name, "_addr"}, 128'(mlog[idx].addr), 128'(a));
      chk({name, "_data"}, mlog[idx].data, d);
    end else begin
      chk({name, "_present"}, 128'(0), 128'(1));
    end
  endtask

  localparam logic [127:0] DA = {16{8'hAA}};
  localparam logic [127:0] D1 = {4{32'h1111_0001}};
  localparam logic [127:0] D2 = {4{32'h2222_0002}};
  localparam logic [127:0] D3 = {4{32'h3333_0003}};
  localparam logic [127:0] D4 = {4{32'h4444_0004}};
  localparam logic [127:0] D5 = {4{32'h5555_0005}};
  localparam logic [127:0] D6 = {4{32'h6666_0006}};
  localparam logic [127:0] D7 = {4{32'h7777_0007}};
  localparam logic [127:0] E1 = {4{32'hE1E1_0001}};
  localparam logic [127:0] E2 = {4{32'hE2E2_0002}};
  localparam logic [127:0] DF = {4{32'hF00D_0008}};

  initial begin
    vec_t         vecs [11];
    int           lat;
    int           base;
    int           rd_base;
    int           ready_cyc;
    bit           early;
    logic [127:0] rd;

    rst_n = 1'b0;

    // Transactions against a stalled memory; head 0x10/D1 stays in flight.
    vecs[0]  = '{1'b1, 28'h10, D1, 128'h0, 1, 1};
    vecs[1]  = '{1'b0, 28'h10, '0, D1,     1, 1};
    vecs[2]  = '{1'b1, 28'h10, D2, 128'h0, 1, 2};
    vecs[3]  = '{1'b0, 28'h10, '0, D2,     1, 2};
    vecs[4]  = '{1'b1, 28'h20, D3, 128'h0, 1, 3};
    vecs[5]  = '{1'b1, 28'h20, D4, 128'h0, 1, 3};
    vecs[6]  = '{1'b0, 28'h20, '0, D4,     1, 3};
    vecs[7]  = '{1'b1, 28'h30, D5, 128'h0, 1, 4};
    vecs[8]  = '{1'b1, 28'h30, D6, 128'h0, 1, 4};
    vecs[9]  = '{1'b0, 28'h30, '0, D6,     1, 4};
    vecs[10] = '{1'b0, 28'h10, '0, D2,     1, 4};

    // Reset values.
    bus.cache_read = 1'b0; bus.cache_write = 1'b0;
    bus.cache_addr = '0;   bus.cache_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cache_ready", 128'(bus.cache_ready), 128'(0));
    chk("rst_mem_write",   128'(bus.mem_write),   128'(0));
    chk("rst_mem_read",    128'(bus.mem_read),    128'(0));
    chk("rst_mem_addr",    128'(bus.mem_addr),    128'(0));
    chk("rst_count",       128'(dut.count),       128'(0));

    // Single write, memory answers after 8 cycles.
    mem_stall = 1'b0;
    mem_lat   = 8;
    do_reset();
    base = mlog.size();
    xact(1'b1, 28'h0000010, DA, 20, lat, rd);
    chk("t1_lat", 128'(lat), 128'(1));
    chk("t1_mem_write", 128'(bus.mem_write), 128'(1));
    chk("t1_mem_addr",  128'(bus.mem_addr),  128'(28'h10));
    chk("t1_mem_wdata", bus.mem_wdata, DA);
    chk("t1_count_1",   128'(dut.count), 128'(1));
    for (int n = 0; n < 50; n++) begin
      if (mlog.size() > base) break;
      @(posedge clk);
      #1;
    end
    chk("t1_count_0",   128'(dut.count), 128'(0));
    chk("t1_write_off", 128'(bus.mem_write), 128'(0));
    chk_log("t1_log", base, 1'b1, 28'h10, DA);

    // Table vectors: forwarding, coalescing, in-flight head, fill to full.
    mem_stall = 1'b1;
    do_reset();
    rd_base = rd_cnt;
    for (int i = 0; i < 11; i++) begin
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 20, lat, rd);
      chk($sformatf("v%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
      if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_count", i), 128'(dut.count), 128'(vecs[i].exp_count));
    end
    chk("tab_no_mem_read",  128'(rd_cnt - rd_base), 128'(0));
    chk("tab_head_write",   128'(bus.mem_write), 128'(1));
    chk("tab_head_addr",    128'(bus.mem_addr),  128'(28'h10));
    chk("tab_head_wdata",   bus.mem_wdata, D1);

    // Fifth write while full: no ready until the head drain retires, then next cycle.
    base = mlog.size();
    bus.cache_write = 1'b1;
    bus.cache_addr  = 28'h40;
    bus.cache_wdata = D7;
    early = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.cache_ready) early = 1'b1;
    end
    chk("full_no_ready", 128'(early), 128'(0));
    mem_lat   = 3;
    mem_stall = 1'b0;
    ready_cyc = -1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (bus.cache_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    bus.cache_write = 1'b0;
    chk("full_ready_cyc", 128'(ready_cyc), 128'(retire_cyc + 1));
    wait_idle("full_drain_done", 300);
    chk("full_log_len", 128'(mlog.size() - base), 128'(5));
    chk_log("full_log0", base + 0, 1'b1, 28'h10, D1);
    chk_log("full_log1", base + 1, 1'b1, 28'h10, D2);
    chk_log("full_log2", base + 2, 1'b1, 28'h20, D4);
    chk_log("full_log3", base + 3, 1'b1, 28'h30, D6);
    chk_log("full_log4", base + 4, 1'b1, 28'h40, D7);
    chk("mem_0x10_final", mem_arr[28'h10], D2);

    // Read miss behind a draining head: head, then the read, then the rest.
    mem_stall = 1'b1;
    do_reset();
    base = mlog.size();
    xact(1'b1, 28'h50, E1, 20, lat, rd);
    xact(1'b1, 28'h60, E2, 20, lat, rd);
    chk("t5_count", 128'(dut.count), 128'(2));
    mem_lat   = 4;
    mem_stall = 1'b0;
    xact(1'b0, 28'h20, '0, 200, lat, rd);
    chk("t5_rdata", rd, mem_pat(28'h20));
    wait_idle("t5_drain_done", 300);
    chk("t5_log_len", 128'(mlog.size() - base), 128'(3));
    chk_log("t5_log0", base + 0, 1'b1, 28'h50, E1);
    chk_log("t5_log1", base + 1, 1'b0, 28'h20, 128'h0);
    chk_log("t5_log2", base + 2, 1'b1, 28'h60, E2);

    // Asynchronous reset in the middle of a drain.
    mem_stall = 1'b1;
    do_reset();
    xact(1'b1, 28'h70, D5, 20, lat, rd);
    chk("t6_draining", 128'(bus.mem_write), 128'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("t6_mem_write",   128'(bus.mem_write),   128'(0));
    chk("t6_mem_read",    128'(bus.mem_read),    128'(0));
    chk("t6_cache_ready", 128'(bus.cache_ready), 128'(0));
    chk("t6_mem_addr",    128'(bus.mem_addr),    128'(0));
    chk("t6_mem_wdata",   bus.mem_wdata,         128'h0);
    chk("t6_cache_rdata", bus.cache_rdata,       128'h0);
    chk("t6_count",       128'(dut.count),       128'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    base      = mlog.size();
    mem_lat   = 2;
    mem_stall = 1'b0;
    xact(1'b1, 28'h80, DF, 20, lat, rd);
    chk("t6_post_lat", 128'(lat), 128'(1));
    wait_idle("t6_drain_done", 100);
    chk("t6_log_len", 128'(mlog.size() - base), 128'(1));
    chk_log("t6_log0", base, 1'b1, 28'h80, DF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
